// File: rtl/spi_reg_access_ctrl.sv
// SPI register-access controller: one CS frame per request (cmd, addr bytes, data bytes), write or read.
// Define SPI_LOOPBACK_EN to sample the receive path from mosi instead of the miso port.
module spi_reg_access_ctrl #(
  parameter int          SPI_MODE          = 3,
  parameter int          LSB_FIRST         = 1,
  parameter int          CLKS_PER_HALF_BIT = 8,
  parameter int          ADDR_BYTES        = 2,
  parameter int          DATA_BYTES        = 2,
  parameter int          CS_SETUP_CLKS     = 1,
  parameter int          CS_INACTIVE_CLKS  = 1,
  parameter logic [7:0]  WR_CMD            = 8'hA1,
  parameter logic [7:0]  RD_CMD            = 8'hA2
) (
  input  logic                    clk40M,
  input  logic                    nRst,
  input  logic                    i_req,
  input  logic [7:0]              i_cmd,
  input  logic [8*ADDR_BYTES-1:0] i_addr,
  input  logic [8*DATA_BYTES-1:0] i_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [8*DATA_BYTES-1:0] o_rdata,
  output logic                    spi_clk,
  output logic                    sl,
  output logic                    mosi,
  input  logic                    miso
);

  localparam bit [1:0] MODE   = 2'(SPI_MODE);
  localparam logic     CPOL   = MODE[1];
  localparam logic     CPHA   = MODE[0];
  localparam int       N      = 8 * (1 + ADDR_BYTES + DATA_BYTES);
  localparam int       DSTART = 8 * (1 + ADDR_BYTES);
  localparam int       DW     = 8 * DATA_BYTES;
  localparam int       EW     = $clog2(2 * N + 1);
  localparam int       RW     = $clog2(DW);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t          state;
  logic [15:0]     tcnt;
  logic [EW-1:0]   ecnt;
  logic [N-1:0]    sr;
  logic [N-1:0]    frame_nx;
  logic [DW-1:0]   rx_buf;
  logic            rd_frame;
  logic            sin;
  logic [EW-1:0]   bit_idx;
  logic            in_data;
  logic [RW-1:0]   rx_pos;

  // Reorders a byte so that bit 0 is always the first bit on the wire.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (LSB_FIRST != 0) ? b[i] : b[7-i];
    return r;
  endfunction

  always_comb begin
    frame_nx = '0;
    frame_nx[7:0] = wire_order(i_cmd);
    for (int i = 0; i < ADDR_BYTES; i++)
      frame_nx[8*(1+i) +: 8] = wire_order(i_addr[8*i +: 8]);
    for (int i = 0; i < DATA_BYTES; i++)
      frame_nx[DSTART + 8*i +: 8] = wire_order(i_wdata[8*i +: 8]);
  end

`ifdef SPI_LOOPBACK_EN
  assign sin = mosi;
`else
  assign sin = miso;
`endif

  // Each sample edge carries bit (ecnt/2); MSB-first bytes land mirrored within the byte.
  assign bit_idx = ecnt >> 1;
  assign in_data = (bit_idx >= EW'(DSTART));
  assign rx_pos  = RW'(bit_idx - EW'(DSTART)) ^ ((LSB_FIRST != 0) ? RW'(0) : RW'(7));

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      tcnt     <= '0;
      ecnt     <= '0;
      sr       <= '0;
      rx_buf   <= '0;
      rd_frame <= 1'b0;
      spi_clk  <= CPOL;
      sl       <= 1'b1;
      mosi     <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: if (i_req) begin
          if (i_cmd == WR_CMD || i_cmd == RD_CMD) begin
            state    <= SETUP;
            o_busy   <= 1'b1;
            sl       <= 1'b0;
            tcnt     <= '0;
            ecnt     <= '0;
            rd_frame <= (i_cmd == RD_CMD);
            if (CPHA == 1'b0) begin
              mosi <= frame_nx[0];
              sr   <= frame_nx >> 1;
            end else begin
              mosi <= 1'b0;
              sr   <= frame_nx;
            end
          end else begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
          end
        end
        SETUP: begin
          tcnt <= tcnt + 16'd1;
          if (tcnt == 16'(CS_SETUP_CLKS - 1)) begin
            state <= SHIFT;
            tcnt  <= '0;
          end
        end
        SHIFT: begin
          tcnt <= tcnt + 16'd1;
          if (tcnt == 16'(CLKS_PER_HALF_BIT - 1)) begin
            tcnt    <= '0;
            spi_clk <= ~spi_clk;
            ecnt    <= ecnt + EW'(1);
            if (ecnt[0] == CPHA) begin
              if (in_data) rx_buf[rx_pos] <= sin;
            end else begin
              mosi <= sr[0];
              sr   <= sr >> 1;
            end
            // Last edge ends the frame; releasing sl also drops mosi.
            if (ecnt == EW'(2 * N - 1)) begin
              state <= GAP;
              sl    <= 1'b1;
              mosi  <= 1'b0;
            end
          end
        end
        GAP: begin
          tcnt <= tcnt + 16'd1;
          if (tcnt == 16'(CS_INACTIVE_CLKS - 1)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            if (rd_frame) o_rdata <= rx_buf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Directed bench for spi_reg_access_ctrl: default-parameter DUT plus a mode-0 MSB-first DUT with mosi wired back to miso.
module tb_spi_reg_access_ctrl;

  logic        clk40M = 1'b0;
  logic        nRst   = 1'b0;
  logic        i_req  = 1'b0;
  logic [7:0]  i_cmd  = 8'h00;
  logic [15:0] i_addr = 16'h0000;
  logic [15:0] i_wdata = 16'h0000;
  logic        o_busy, o_done, o_err, spi_clk, sl, mosi;
  logic        miso = 1'b0;
  logic [15:0] o_rdata;

  logic        req2 = 1'b0;
  logic [7:0]  cmd2 = 8'h00;
  logic [7:0]  addr2 = 8'h00;
  logic [31:0] wdata2 = 32'h0;
  logic        busy2, done2, err2, sclk2, sl2, mosi2, miso2;
  logic [31:0] rdata2;

  int nchecks = 0;
  int nerrors = 0;

  always #10 clk40M = ~clk40M;

  spi_reg_access_ctrl dut (
    .clk40M(clk40M), .nRst(nRst), .i_req(i_req), .i_cmd(i_cmd), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .spi_clk(spi_clk), .sl(sl), .mosi(mosi), .miso(miso)
  );

  assign miso2 = mosi2;
  spi_reg_access_ctrl #(.SPI_MODE(0), .LSB_FIRST(0), .ADDR_BYTES(1), .DATA_BYTES(4)) dut2 (
    .clk40M(clk40M), .nRst(nRst), .i_req(req2), .i_cmd(cmd2), .i_addr(addr2),
    .i_wdata(wdata2), .o_busy(busy2), .o_done(done2), .o_err(err2),
    .o_rdata(rdata2), .spi_clk(sclk2), .sl(sl2), .mosi(mosi2), .miso(miso2)
  );

  // SPI slave model for mode 3, LSB first: shifts 16'h5A3C out during the data phase.
  logic [15:0] slave_pat = 16'h5A3C;
  int mk = 0;
  always @(negedge sl) mk = 0;
  always @(negedge spi_clk) if (!sl) begin
    if (mk >= 24 && mk < 40) miso = slave_pat[mk-24];
    else miso = 1'b0;
    mk++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          r_done_cyc, r_sl_low, r_edges, r_nbits;
  logic        r_busy1, r_sl1, r_busy_done, r_err, r_mosi_done;
  logic [39:0] r_cap;
  logic [15:0] r_rdata;

  // Issues one request and follows it to o_done, recording wire activity.
  task automatic do_frame(input logic [7:0] c, input logic [15:0] a, input logic [15:0] w);
    logic prev_clk, mlast;
    @(negedge clk40M);
    i_cmd = c; i_addr = a; i_wdata = w; i_req = 1'b1;
    @(posedge clk40M);
    @(negedge clk40M);
    i_req = 1'b0;
    r_done_cyc = -1; r_sl_low = 0; r_edges = 0; r_nbits = 0; r_cap = '0;
    r_busy1 = o_busy; r_sl1 = sl; prev_clk = 1'b1; mlast = 1'b0;
    for (int cyc = 1; cyc < 1000; cyc++) begin
      if (!sl) r_sl_low++;
      if (spi_clk !== prev_clk) r_edges++;
      if (!prev_clk && spi_clk) begin
        if (r_nbits < 40) r_cap[r_nbits] = mlast;
        r_nbits++;
      end
      if (!spi_clk) mlast = mosi;
      prev_clk = spi_clk;
      if (o_done) begin
        r_done_cyc = cyc; r_busy_done = o_busy; r_err = o_err;
        r_rdata = o_rdata; r_mosi_done = mosi;
        break;
      end
      @(negedge clk40M);
    end
  endtask

  initial begin
    int ndone, nfall, gap;
    logic prev_sl, prev_clk2;
    logic [7:0] cap2;
    int nb2, d2cyc;

    #35;
    check("rst_sl", sl, 1'b1);
    check("rst_spi_clk", spi_clk, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_rdata", o_rdata, 16'h0);
    @(negedge clk40M);
    nRst = 1'b1;

    // Write with defaults
    do_frame(8'hA1, 16'h1234, 16'hBEEF);
    check("wr_busy_c1", r_busy1, 1'b1);
    check("wr_sl_c1", r_sl1, 1'b0);
    check("wr_sl_low", r_sl_low, 641);
    check("wr_done_cyc", r_done_cyc, 643);
    check("wr_busy_done", r_busy_done, 1'b0);
    check("wr_err", r_err, 1'b0);
    check("wr_edges", r_edges, 80);
    check("wr_wire", r_cap, {16'hBEEF, 16'h1234, 8'hA1});
    check("wr_mosi_done", r_mosi_done, 1'b0);
    check("wr_rdata", r_rdata, 16'h0);
    check("wr_clk_idle", spi_clk, 1'b1);

    // Read, slave returns 5A3C
    do_frame(8'hA2, 16'h0010, 16'h0000);
    check("rd_done_cyc", r_done_cyc, 643);
    check("rd_rdata", r_rdata, 16'h5A3C);
    check("rd_err", r_err, 1'b0);
    check("rd_wire", r_cap[23:0], {16'h0010, 8'hA2});

    do_frame(8'hA1, 16'hFFFF, 16'h0001);
    check("wr2_rdata_hold", r_rdata, 16'h5A3C);

    // Unknown command
    @(negedge clk40M);
    i_cmd = 8'h77; i_req = 1'b1;
    @(posedge clk40M);
    @(negedge clk40M);
    i_req = 1'b0;
    check("unk_done", o_done, 1'b1);
    check("unk_err", o_err, 1'b1);
    check("unk_busy", o_busy, 1'b0);
    check("unk_sl", sl, 1'b1);
    check("unk_clk", spi_clk, 1'b1);
    check("unk_rdata", o_rdata, 16'h5A3C);
    @(negedge clk40M);
    check("unk_done_c2", o_done, 1'b0);
    check("unk_sl_c2", sl, 1'b1);

    // Back-to-back with i_req held
    i_cmd = 8'hA1; i_addr = 16'h5555; i_wdata = 16'hAAAA; i_req = 1'b1;
    ndone = 0; nfall = 0; gap = 0; prev_sl = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk40M);
      if (prev_sl && !sl) nfall++;
      if (nfall == 1 && sl) gap++;
      if (o_done) ndone++;
      if (ndone == 1 && nfall == 2) i_req = 1'b0;
      prev_sl = sl;
    end
    i_req = 1'b0;
    check("b2b_frames", nfall, 2);
    check("b2b_dones", ndone, 2);
    check("b2b_gap", gap, 2);

    // Reset mid-frame
    @(negedge clk40M);
    i_cmd = 8'hA1; i_req = 1'b1;
    @(posedge clk40M);
    @(negedge clk40M);
    i_req = 1'b0;
    repeat (299) @(negedge clk40M);
    check("mid_sl_before", sl, 1'b0);
    nRst = 1'b0;
    #1;
    check("mid_rst_sl", sl, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_clk", spi_clk, 1'b1);
    check("mid_rst_rdata", o_rdata, 16'h0);
    @(negedge clk40M);
    nRst = 1'b1;
    do_frame(8'hA2, 16'h0020, 16'h0000);
    check("post_rst_done", r_done_cyc, 643);
    check("post_rst_rdata", r_rdata, 16'h5A3C);

    // Mode 0, MSB first, mosi looped to miso
    check("lb_clk_idle", sclk2, 1'b0);
    @(negedge clk40M);
    cmd2 = 8'hA2; addr2 = 8'h05; wdata2 = 32'hCAFEF00D; req2 = 1'b1;
    @(posedge clk40M);
    @(negedge clk40M);
    req2 = 1'b0;
    prev_clk2 = 1'b0; cap2 = '0; nb2 = 0; d2cyc = -1;
    for (int cyc = 1; cyc < 1000; cyc++) begin
      if (!prev_clk2 && sclk2 && nb2 < 8) begin
        cap2 = {cap2[6:0], mosi2};
        nb2++;
      end
      prev_clk2 = sclk2;
      if (done2) begin
        d2cyc = cyc;
        break;
      end
      @(negedge clk40M);
    end
    check("lb_done_cyc", d2cyc, 771);
    check("lb_cmd_msb", cap2, 8'hA2);
    check("lb_rdata", rdata2, 32'hCAFEF00D);
    check("lb_err", err2, 1'b0);
    check("lb_clk_end", sclk2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
